// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifft_pkg
// Description : Shared defaults and the address bit-reverse helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ifft_pkg;

    localparam int c_dw_default    = 28;
    localparam int c_depth_default = 32;
    localparam int c_max_aw        = 16;

    // Reverses the low w bits of a; bits at or above w are returned as zero.
    function automatic logic [c_max_aw-1:0] bit_reverse(input logic [c_max_aw-1:0] a,
                                                        input int w);
        logic [c_max_aw-1:0] r;
        r = '0;
        for (int i = 0; i < c_max_aw; i++) begin
            if (i < w) begin
                r[i] = a[w-1-i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : sp_bank_ram
// Description : One sample bank: synchronous write, registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_bank_ram
    import ifft_pkg::*;
#(
    parameter int DW    = c_dw_default,
    parameter int DEPTH = c_depth_default,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_q <= r_mem[raddr];
        end
    end

    assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/pp_sample_buf.sv
`default_nettype none
// ============================================================================
// Module      : pp_sample_buf
// Description : Two-bank ping-pong sample buffer with optional bit-reversed reads.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_sample_buf
    import ifft_pkg::*;
#(
    parameter int DW     = c_dw_default,
    parameter int DEPTH  = c_depth_default,
    parameter int BITREV = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wr_done,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rd_valid,
    input  logic          rd_done,
    output logic          rd_ready,
    output logic          err_ovf,
    output logic          err_udf
);

    logic          r_wb;
    logic          r_rb;
    logic [1:0]    r_fc;
    logic          r_rd_valid;
    logic          r_rd_sel;
    logic          r_rd_loaded;
    logic          r_err_ovf;
    logic          r_err_udf;

    logic          w_wr_ready;
    logic          w_rd_ready;
    logic          w_wr_acc;
    logic          w_wd_acc;
    logic          w_rd_acc;
    logic          w_rdone_acc;
    logic [AW-1:0] w_eff_addr;
    logic [DW-1:0] w_bank_q [2];

    assign w_wr_ready  = (r_fc != 2'd2);
    assign w_rd_ready  = (r_fc != 2'd0);
    assign w_wr_acc    = wr_en   & w_wr_ready;
    assign w_wd_acc    = wr_done & w_wr_ready;
    assign w_rd_acc    = rd_en   & w_rd_ready;
    assign w_rdone_acc = rd_done & w_rd_ready;

    if (BITREV != 0) begin : g_bitrev
        assign w_eff_addr = AW'(bit_reverse(c_max_aw'(raddr), AW));
    end else begin : g_direct
        assign w_eff_addr = raddr;
    end

    // Pointer rules keep writer and reader on different banks whenever fc=1.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        sp_bank_ram #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .we    (w_wr_acc && (r_wb == 1'(b))),
            .waddr (waddr),
            .wdata (wdata),
            .re    (w_rd_acc && (r_rb == 1'(b))),
            .raddr (w_eff_addr),
            .rdata (w_bank_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_fc        <= 2'd0;
            r_rd_valid  <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_rd_loaded <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_udf   <= 1'b0;
        end else begin
            if (w_wd_acc) begin
                r_wb <= ~r_wb;
            end
            if (w_rdone_acc) begin
                r_rb <= ~r_rb;
            end
            case ({w_wd_acc, w_rdone_acc})
                2'b10:   r_fc <= r_fc + 2'd1;
                2'b01:   r_fc <= r_fc - 2'd1;
                default: r_fc <= r_fc;
            endcase
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_sel    <= r_rb;
                r_rd_loaded <= 1'b1;
            end
            if ((wr_en | wr_done) & ~w_wr_ready) begin
                r_err_ovf <= 1'b1;
            end
            if ((rd_en | rd_done) & ~w_rd_ready) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // The bank read registers hold between reads; r_rd_loaded gives rdata=0 after reset.
    assign rdata    = r_rd_loaded ? w_bank_q[r_rd_sel] : '0;
    assign rd_valid = r_rd_valid;
    assign wr_ready = w_wr_ready;
    assign rd_ready = w_rd_ready;
    assign err_ovf  = r_err_ovf;
    assign err_udf  = r_err_udf;

endmodule
`default_nettype wire

// File: tb/tb_pp_sample_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_sample_buf
// Description : Scoreboard bench driving a direct and a bit-reversed instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_sample_buf;

    localparam int DW    = 28;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;

    logic          wr_ready0, rd_ready0, rd_valid0, err_ovf0, err_udf0;
    logic          wr_ready1, rd_ready1, rd_valid1, err_ovf1, err_udf1;
    logic [DW-1:0] rdata0, rdata1;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    always #5 clk = ~clk;

    pp_sample_buf #(.DW(DW), .DEPTH(DEPTH), .BITREV(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
        .wr_done(wr_done), .wr_ready(wr_ready0), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata0), .rd_valid(rd_valid0), .rd_done(rd_done), .rd_ready(rd_ready0),
        .err_ovf(err_ovf0), .err_udf(err_udf0)
    );

    pp_sample_buf #(.DW(DW), .DEPTH(DEPTH), .BITREV(1)) u_dut_rev (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
        .wr_done(wr_done), .wr_ready(wr_ready1), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata1), .rd_valid(rd_valid1), .rd_done(rd_done), .rd_ready(rd_ready1),
        .err_ovf(err_ovf1), .err_udf(err_udf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] rev5(input logic [AW-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid0) begin
            if (q0.size() == 0) chk("rd0_unexpected", 32'(rd_valid0), 32'd0);
            else                chk("rd0_data", 32'(rdata0), 32'(q0.pop_front()));
        end
        if (rd_valid1) begin
            if (q1.size() == 0) chk("rd1_unexpected", 32'(rd_valid1), 32'd0);
            else                chk("rd1_data", 32'(rdata1), 32'(q1.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; waddr = AW'(a); wdata = DW'(d);
        step();
    endtask

    task automatic read(input int a, input int e0, input int e1);
        rd_en = 1'b1; raddr = AW'(a);
        q0.push_back(DW'(e0));
        q1.push_back(DW'(e1));
        step();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_wr_ready", 32'(wr_ready0), 32'd1);
        chk("rst_rd_ready", 32'(rd_ready0), 32'd0);
        chk("rst_rdata", 32'(rdata0), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid0), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf0), 32'd0);
        chk("rst_err_udf", 32'(err_udf0), 32'd0);

        // Read from an empty buffer is rejected and flagged.
        rd_en = 1'b1; raddr = 5'd3;
        step();
        chk("empty_rd_valid", 32'(rd_valid0), 32'd0);
        chk("empty_rdata", 32'(rdata0), 32'd0);
        chk("empty_err_udf0", 32'(err_udf0), 32'd1);
        chk("empty_err_udf1", 32'(err_udf1), 32'd1);
        chk("empty_err_ovf", 32'(err_ovf0), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("udf_cleared", 32'(err_udf0), 32'd0);

        // Fill bank0 with addr+100, then read address 5.
        for (int a = 0; a < DEPTH; a++) write(a, a + 100);
        wr_done = 1'b1;
        step();
        chk("fill_rd_ready", 32'(rd_ready0), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready0), 32'd1);
        read(5, 105, 120);

        // Ping-pong: fill bank1 with addr+200 while reading bank0.
        for (int i = 0; i < DEPTH; i++) begin
            int ra;
            ra = (i * 7 + 3) % DEPTH;
            wr_en = 1'b1; waddr = AW'(i); wdata = DW'(i + 200);
            rd_en = 1'b1; raddr = AW'(ra);
            q0.push_back(DW'(ra + 100));
            q1.push_back(DW'(int'(rev5(AW'(ra))) + 100));
            step();
        end
        read(1, 101, 116);

        // Both banks full: writes rejected, memory untouched.
        wr_done = 1'b1;
        step();
        chk("full_wr_ready", 32'(wr_ready0), 32'd0);
        chk("full_rd_ready", 32'(rd_ready0), 32'd1);
        write(5, 999);
        chk("full_err_ovf0", 32'(err_ovf0), 32'd1);
        chk("full_err_ovf1", 32'(err_ovf1), 32'd1);
        read(5, 105, 120);

        rd_done = 1'b1;
        step();
        chk("drain_wr_ready", 32'(wr_ready0), 32'd1);
        chk("drain_rd_ready", 32'(rd_ready0), 32'd1);
        read(5, 205, 220);

        // Refill bank0 with addr+300, then swap both pointers at once.
        for (int a = 0; a < DEPTH; a++) write(a, a + 300);
        wr_done = 1'b1; rd_done = 1'b1; rd_en = 1'b1; raddr = 5'd7;
        q0.push_back(DW'(207));
        q1.push_back(DW'(228));
        step();
        chk("swap_wr_ready", 32'(wr_ready0), 32'd1);
        chk("swap_rd_ready", 32'(rd_ready0), 32'd1);
        read(5, 305, 320);
        write(9, 777);
        wr_done = 1'b1;
        step();
        chk("swap_full", 32'(wr_ready0), 32'd0);
        rd_done = 1'b1;
        step();
        read(9, 777, 218);

        // Reset asserted together with a read wins over the read.
        rst_n = 1'b0; rd_en = 1'b1; raddr = 5'd2;
        step();
        rst_n = 1'b1;
        chk("midrst_rd_valid", 32'(rd_valid0), 32'd0);
        chk("midrst_rdata0", 32'(rdata0), 32'd0);
        chk("midrst_rdata1", 32'(rdata1), 32'd0);
        chk("midrst_rd_ready", 32'(rd_ready0), 32'd0);
        chk("midrst_wr_ready", 32'(wr_ready0), 32'd1);
        chk("midrst_err_ovf", 32'(err_ovf0), 32'd0);

        step();
        step();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pp_sample_buf.md
PP_SAMPLE_BUF -- requirements
Module: pp_sample_buf

Interface
REQ-001 The block SHALL have parameter DW, default 28, giving the sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving words per bank; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter BITREV, default 0; when 1, read addresses are bit-reversed over AW bits.
REQ-004 The block SHALL use derived constant AW = clog2(DEPTH).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write strobe.
REQ-008 The block SHALL have port waddr, input, AW bits: write address within the writer bank.
REQ-009 The block SHALL have port wdata, input, DW bits: write data.
REQ-010 The block SHALL have port wr_done, input, 1 bit: pulse that marks the writer bank as full.
REQ-011 The block SHALL have port wr_ready, output, 1 bit: a writer bank is available.
REQ-012 The block SHALL have port rd_en, input, 1 bit: read strobe.
REQ-013 The block SHALL have port raddr, input, AW bits: read address within the reader bank.
REQ-014 The block SHALL have port rdata, output, DW bits: registered read data.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: rdata updated this cycle.
REQ-016 The block SHALL have port rd_done, input, 1 bit: pulse that releases the reader bank.
REQ-017 The block SHALL have port rd_ready, output, 1 bit: a full bank is readable.
REQ-018 The block SHALL have port err_ovf, output, 1 bit: sticky flag for a write or wr_done attempted while wr_ready=0.
REQ-019 The block SHALL have port err_udf, output, 1 bit: sticky flag for a read or rd_done attempted while rd_ready=0.

Function
REQ-020 The block SHALL store two banks of DEPTH x DW words, with a writer bank pointer wb and a reader bank pointer rb of 1 bit each.
REQ-021 The block SHALL hold full-bank count fc in {0,1,2}, driving wr_ready = (fc<2) and rd_ready = (fc>0).
REQ-022 The block SHALL, when wr_en=1 and wr_ready=1, write wdata to bank wb at waddr on the clock edge.
REQ-023 The block SHALL, when wr_done=1 and wr_ready=1, toggle wb and increment fc.
REQ-024 The block SHALL, when wr_en and wr_done are high in the same cycle, write into the old wb before the swap.
REQ-025 The block SHALL, when rd_en=1 and rd_ready=1, load rdata from bank rb at eff_addr one cycle later and assert rd_valid for that one cycle.
REQ-026 The block SHALL compute eff_addr = raddr when BITREV=0, and raddr with its AW bits reversed when BITREV=1.
REQ-027 The block SHALL, when rd_done=1 and rd_ready=1, toggle rb and decrement fc; a read issued in the same cycle uses the old rb.
REQ-028 The block SHALL, on simultaneous accepted wr_done and rd_done, toggle both pointers and leave fc unchanged.
REQ-029 The block SHALL ignore rejected requests: no memory or pointer change, rdata holds, rd_valid=0.
REQ-030 The block SHALL set err_ovf on wr_en or wr_done while wr_ready=0, and err_udf on rd_en or rd_done while rd_ready=0; both clear only on reset.
REQ-031 The block SHALL never let the writer and reader access the same bank while fc=1; this follows from the pointer rules and must not need bypass logic.
REQ-032 The block SHALL return rdata unchanged from the prior read while rd_en=0.

Reset
REQ-033 The block SHALL, when rst_n=0 at a clock edge, set wb=0, rb=0, fc=0, rdata=0, rd_valid=0, err_ovf=0 and err_udf=0, giving wr_ready=1 and rd_ready=0.
REQ-034 The block SHALL NOT clear memory contents on reset.
REQ-035 The block SHALL give rst_n priority over all requests in the same cycle, including reset asserted mid-fill or mid-drain.

Structure
REQ-036 The block SHALL take DW and DEPTH defaults, and a bit-reverse function, from shared package ifft_pkg.
REQ-037 The block SHALL instantiate one sub-module, sp_bank_ram (parametrised DW/DEPTH, synchronous write, registered read), twice, one per bank.

Verification
REQ-038 Bench SHALL cover basic fill and drain: write 0..31 with data=addr+100, pulse wr_done, then read addr 5 -> rd_ready=1, and one cycle later rdata=105 with rd_valid=1.
REQ-039 Bench SHALL cover ping-pong: fill bank0, wr_done, fill bank1 with data=addr+200 while reading bank0 -> reads return addr+100, with no corruption.
REQ-040 Bench SHALL cover full: two wr_done pulses without any rd_done -> wr_ready=0; a further wr_en leaves memory unchanged and sets err_ovf=1.
REQ-041 Bench SHALL cover empty: rd_en after reset -> rd_valid=0, rdata=0 and err_udf=1.
REQ-042 Bench SHALL cover BITREV=1 with DEPTH=32: raddr=1 -> returns the word written at address 16.
REQ-043 Bench SHALL cover simultaneous swap: with fc=1, pulse wr_done and rd_done together -> fc stays 1, and both wb and rb toggle.
